// File: rtl/cb_pkg.sv
// Shared types and sizes for the brightness/contrast restore path.
package cb_pkg;
   localparam int PIX_W  = 8;
   localparam int LANES  = 4;
   localparam int WORD_W = PIX_W * LANES;

   typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} cb_state_t;
   typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/byte_div8.sv
// One lane of restoring division: quotient bits shift in MSB first, one per step.
module byte_div8
   import cb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic step,
   input  pix_t dividend,
   input  pix_t divisor,
   output pix_t quotient
);

   pix_t           rem_q, rem_d;
   pix_t           quo_q, quo_d;
   pix_t           dvsr_q;
   logic [PIX_W:0] trial;
   logic [PIX_W:0] trial_sub;
   logic           fits;

   // quo_q starts as the dividend and is gradually replaced by quotient bits
   always_comb begin
      trial     = {rem_q, quo_q[PIX_W-1]};
      trial_sub = trial - {1'b0, dvsr_q};
      fits      = (trial >= {1'b0, dvsr_q});
      rem_d     = fits ? trial_sub[PIX_W-1:0] : trial[PIX_W-1:0];
      quo_d     = {quo_q[PIX_W-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
      end else if (load) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvsr_q <= divisor;
      end else if (step) begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
      end
   end

   assign quotient = quo_q;

endmodule

// File: rtl/bright_restore.sv
// Undo of the contrast/brightness stage: pix = floor((adj - beta) / alpha) on four lanes.
module bright_restore
   import cb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_word,
   input  pix_t              alpha,
   input  pix_t              beta,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [LANES-1:0]  out_clamp,
   output logic              div_zero,
   output logic              out_valid,
   input  logic              out_ready
);

   cb_state_t         state_q;
   logic [2:0]        cnt_q;
   logic [WORD_W-1:0] adj_q;
   pix_t              alpha_q, beta_q;
   logic [LANES-1:0]  clamp_q, clamp_d;
   logic              dz_q, in_ready_q, out_valid_q;
   pix_t              diff_d [LANES];
   pix_t              quo    [LANES];
   logic [WORD_W-1:0] quo_word;
   logic              accept, load, step;

   // Lanes below the offset are clamped to zero before division
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         clamp_d[i] = (adj_q[i*PIX_W +: PIX_W] < beta_q);
         diff_d[i]  = clamp_d[i] ? '0 : (adj_q[i*PIX_W +: PIX_W] - beta_q);
      end
   end

   assign accept = in_valid & in_ready_q;
   assign load   = (state_q == SUB);
   assign step   = (state_q == DIV);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      byte_div8 u_div (
         .clk      (clk),
         .rst      (rst),
         .load     (load),
         .step     (step),
         .dividend (diff_d[g]),
         .divisor  (alpha_q),
         .quotient (quo[g])
      );
   end

   always_comb begin
      quo_word = '0;
      for (int i = 0; i < LANES; i++) quo_word[i*PIX_W +: PIX_W] = quo[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         clamp_q     <= '0;
         dz_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               adj_q      <= in_word;
               alpha_q    <= alpha;
               beta_q     <= beta;
               in_ready_q <= 1'b0;
               state_q    <= SUB;
            end
            SUB: begin
               clamp_q <= clamp_d;
               if (alpha_q == '0) begin
                  dz_q        <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q   <= 3'd7;
                  state_q <= DIV;
               end
            end
            DIV: begin
               if (cnt_q == 3'd0) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               clamp_q     <= '0;
               dz_q        <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A zero divisor reports all-ones; nothing is driven outside the valid window
   assign out_word  = !out_valid_q ? '0 : (dz_q ? '1 : quo_word);
   assign out_clamp = clamp_q;
   assign div_zero  = dz_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

endmodule
